// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the keypad emulator: matrix geometry, key index encoding and FSM states.
package keypad_emulator_pkg;

  localparam int NUM_COLS = 3;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;
  localparam int KEY_W    = 4;

  typedef logic [KEY_W-1:0]            key_t;
  typedef logic [$clog2(NUM_COLS)-1:0] col_idx_t;
  typedef logic [$clog2(NUM_ROWS)-1:0] row_idx_t;

  // Keys used by the coin/button replay sources.
  localparam key_t KEY_COIN  = 4'd0;
  localparam key_t KEY_START = 4'd1;

  // Column pattern that opens a scan frame: column 0 strobed low.
  localparam logic [NUM_COLS-1:0] FRAME_START_COL = {{(NUM_COLS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  function automatic logic key_is_valid(input key_t k);
    return k < key_t'(NUM_KEYS);
  endfunction

  function automatic col_idx_t key_col(input key_t k);
    return col_idx_t'(k / key_t'(NUM_ROWS));
  endfunction

  function automatic row_idx_t key_row(input key_t k);
    return row_idx_t'(k % key_t'(NUM_ROWS));
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Scanner pins plus the press-command handshake; master = scanner/command side, slave = emulator.
interface keypad_emulator_if;
  import keypad_emulator_pkg::*;

  logic [NUM_COLS-1:0] col;
  logic [NUM_ROWS-1:0] row;
  logic                cmd_valid;
  key_t                cmd_key;
  logic                cmd_ready;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output col, cmd_valid, cmd_key,
    input  row, cmd_ready, busy, done, err
  );

  modport slave (
    input  col, cmd_valid, cmd_key,
    output row, cmd_ready, busy, done, err
  );

endinterface

// File: rtl/keypad_emulator_scan_frame_detect.sv
// Registers the column strobes and flags the start of each scan frame; also reports whether the
// live strobe pattern is a legal single-column select.
module keypad_emulator_scan_frame_detect
  import keypad_emulator_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] col_i,
  output logic                one_hot_o,
  output logic                boundary_o
);

  logic [NUM_COLS-1:0] col_q;
  logic [NUM_COLS-1:0] col_prev_q;

  // NOTE: non-blocking so col_prev_q takes the pre-edge col_q; blocking would collapse the two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '1;
      col_prev_q <= '1;
    end else begin
      col_q      <= col_i;
      col_prev_q <= col_q;
    end
  end

  assign one_hot_o  = ($countones(~col_i) == 1);
  assign boundary_o = (col_q == FRAME_START_COL) && (col_prev_q != FRAME_START_COL);

endmodule

// File: rtl/keypad_emulator.sv
// Keypad matrix responder: holds one injected key for HOLD_SCANS frames, releases for GAP_SCANS
// frames, then pulses done; a stalled scanner aborts the press with err.
module keypad_emulator
  import keypad_emulator_pkg::*;
#(
  parameter int HOLD_SCANS     = 20,
  parameter int GAP_SCANS      = 20,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  keypad_emulator_if.slave  kp
);

  localparam int FRAME_MAX = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int WD_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FRAME_W-1:0] HOLD_LAST = FRAME_W'(HOLD_SCANS - 1);
  localparam logic [FRAME_W-1:0] GAP_LAST  = FRAME_W'(GAP_SCANS - 1);
  localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  key_t                 key_q, key_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 col_one_hot;
  logic                 boundary;
  logic [NUM_ROWS-1:0]  row_n;

  keypad_emulator_scan_frame_detect u_frame_detect (
    .clk        (clk),
    .reset      (reset),
    .col_i      (kp.col),
    .one_hot_o  (col_one_hot),
    .boundary_o (boundary)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      frame_cnt_q <= '0;
      wd_cnt_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      frame_cnt_q <= frame_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    frame_cnt_d = frame_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (kp.cmd_valid) begin
          if (key_is_valid(kp.cmd_key)) begin
            state_d     = ST_PRESS;
            key_d       = kp.cmd_key;
            frame_cnt_d = '0;
            wd_cnt_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PRESS, ST_RELEASE: begin
        // A boundary always wins over the watchdog: a live scanner is never aborted.
        if (boundary) begin
          wd_cnt_d = '0;
          if (frame_cnt_q == ((state_q == ST_PRESS) ? HOLD_LAST : GAP_LAST)) begin
            frame_cnt_d = '0;
            if (state_q == ST_PRESS) begin
              state_d = ST_RELEASE;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Matrix model: zero-latency path from the live column strobe, suppressed for illegal strobes.
  always_comb begin
    row_n = '1;
    if (state_q == ST_PRESS && col_one_hot && !kp.col[key_col(key_q)]) begin
      row_n[key_row(key_q)] = 1'b0;
    end
  end

  assign kp.row       = row_n;
  assign kp.cmd_ready = (state_q == ST_IDLE);
  assign kp.busy      = (state_q != ST_IDLE);
  assign kp.done      = done_q;
  assign kp.err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator: a transaction-level press model predicts every output each
// cycle, with directed scenarios for invalid keys, ignored commands, scanner stall, reset and bad strobes.
module tb_keypad_emulator;
  import keypad_emulator_pkg::*;

  localparam int HOLD = 20;
  localparam int GAP  = 20;
  localparam int TMO  = 100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_emulator_if ifc ();

  keypad_emulator #(
    .HOLD_SCANS     (HOLD),
    .GAP_SCANS      (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
  endtask

  // Reference model: a press is "boundaries seen since accept"; phase follows from that count.
  bit       m_active = 1'b0;
  int       m_key    = 0;
  int       m_bcount = 0;
  int       m_quiet  = 0;
  bit       m_done   = 1'b0;
  bit       m_err    = 1'b0;
  bit       m_bnd    = 1'b0;
  logic [2:0] s1 = 3'b111;
  logic [2:0] s2 = 3'b111;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_active = 1'b0; m_key = 0; m_bcount = 0; m_quiet = 0;
        m_done = 1'b0; m_err = 1'b0; s1 = 3'b111; s2 = 3'b111;
      end else begin
        m_bnd  = (s1 == 3'b110) && (s2 != 3'b110);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_active) begin
          if (ifc.cmd_valid) begin
            if (ifc.cmd_key >= 4'd12) m_err = 1'b1;
            else begin
              m_active = 1'b1; m_key = int'(ifc.cmd_key); m_bcount = 0; m_quiet = 0;
            end
          end
        end else if (m_bnd) begin
          m_bcount++;
          m_quiet = 0;
          if (m_bcount == HOLD + GAP) begin m_active = 1'b0; m_done = 1'b1; end
        end else begin
          m_quiet++;
          if (m_quiet == TMO) begin m_active = 1'b0; m_err = 1'b1; end
        end
        s2 = s1;
        s1 = ifc.col;
      end
    end
  end

  function automatic logic [3:0] exp_row(input logic [2:0] c);
    logic [3:0] r;
    r = 4'hF;
    if (m_active && m_bcount < HOLD && $countones(~c) == 1 && c[m_key / 4] == 1'b0)
      r[m_key % 4] = 1'b0;
    return r;
  endfunction

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (cmp_en && !reset) begin
        check("row",       8'(ifc.row),       8'(exp_row(ifc.col)));
        check("cmd_ready", 8'(ifc.cmd_ready), 8'(!m_active));
        check("busy",      8'(ifc.busy),      8'(m_active));
        check("done",      8'(ifc.done),      8'(m_done));
        check("err",       8'(ifc.err),       8'(m_err));
      end
    end
  end

  // Scanner: 0 = running with random dwell, 1 = frozen on col0, 2 = illegal all-low, 3 = idle.
  int scan_mode = 0;
  int sc_idx    = 0;
  int sc_dwell  = 0;

  initial begin
    ifc.col = 3'b111;
    forever begin
      @(negedge clk);
      case (scan_mode)
        0: begin
          if (sc_dwell == 0) begin
            sc_idx   = (sc_idx + 1) % 3;
            sc_dwell = $urandom_range(1, 3);
          end
          sc_dwell--;
          if ($urandom_range(0, 9) == 0) ifc.col = 3'b111;
          else                           ifc.col = ~(3'b001 << sc_idx);
        end
        1:       ifc.col = 3'b110;
        2:       ifc.col = 3'b000;
        default: ifc.col = 3'b111;
      endcase
    end
  end

  task automatic send(input int key);
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_key   = 4'(key);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit got_done, output bit got_err,
                          output bit rdy, output int cyc, output int n_row0_low);
    got_done = 1'b0; got_err = 1'b0; rdy = 1'b0; cyc = 0; n_row0_low = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (ifc.row[0] == 1'b0) n_row0_low++;
      if (ifc.done || ifc.err) begin
        got_done = ifc.done; got_err = ifc.err; rdy = ifc.cmd_ready; cyc = i;
        return;
      end
    end
    bound_expired("wait_end");
  endtask

  task automatic find_press_col(input logic [2:0] c, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (ifc.col == c && m_active && m_bcount < HOLD) begin
        found = 1'b1;
        return;
      end
    end
    bound_expired("find_press_col");
  endtask

  bit d, e, r, f;
  int cyc, row0;
  int rkey;

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_key   = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("rst_row",   8'(ifc.row),       8'h0F);
    check("rst_ready", 8'(ifc.cmd_ready), 8'd1);
    check("rst_busy",  8'(ifc.busy),      8'd0);
    check("rst_done",  8'(ifc.done),      8'd0);
    check("rst_err",   8'(ifc.err),       8'd0);

    // Key 5 = col1,row1
    send(5);
    find_press_col(3'b101, f);
    if (f) check("t1_row_col1", 8'(ifc.row), 8'b1101);
    find_press_col(3'b011, f);
    if (f) check("t1_row_col2", 8'(ifc.row), 8'h0F);
    wait_end(2000, d, e, r, cyc, row0);
    check("t1_done",  8'(d), 8'd1);
    check("t1_err",   8'(e), 8'd0);
    check("t1_ready", 8'(r), 8'd1);

    // Out-of-range key
    send(12);
    #1;
    check("t2_err",   8'(ifc.err),       8'd1);
    check("t2_ready", 8'(ifc.cmd_ready), 8'd1);
    check("t2_busy",  8'(ifc.busy),      8'd0);
    check("t2_row",   8'(ifc.row),       8'h0F);
    @(negedge clk);
    #1;
    check("t2_err_pulse", 8'(ifc.err), 8'd0);

    // Command while busy is dropped; key 0 (row0) must never show
    send(7);
    repeat (5) @(negedge clk);
    send(0);
    wait_end(2000, d, e, r, cyc, row0);
    check("t3_done",      8'(d),    8'd1);
    check("t3_key0_never", 8'(row0), 8'd0);

    // Scanner stall
    send(4);
    repeat (6) @(negedge clk);
    scan_mode = 1;
    wait_end(2000, d, e, r, cyc, row0);
    check("t4_err",  8'(e), 8'd1);
    check("t4_done", 8'(d), 8'd0);
    check("t4_latency_window", 8'(cyc >= 94 && cyc <= 102), 8'd1);
    @(negedge clk);
    #1;
    check("t4_busy", 8'(ifc.busy), 8'd0);
    check("t4_row",  8'(ifc.row),  8'h0F);
    scan_mode = 0;

    // Reset during press of key 3 (col0,row3)
    send(3);
    find_press_col(3'b110, f);
    if (f) check("t5_row_pressed", 8'(ifc.row), 8'b0111);
    #1 reset = 1'b1;
    #1;
    check("t5_row_async",  8'(ifc.row),  8'h0F);
    check("t5_busy_async", 8'(ifc.busy), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_ready", 8'(ifc.cmd_ready), 8'd1);
    check("t5_done",  8'(ifc.done),      8'd0);
    check("t5_err",   8'(ifc.err),       8'd0);
    repeat (5) @(negedge clk);

    // Illegal multi-low strobe during press of key 0
    send(0);
    repeat (2) @(negedge clk);
    scan_mode = 2;
    repeat (4) @(negedge clk);
    #1;
    check("t6_row_illegal", 8'(ifc.row),  8'h0F);
    check("t6_busy",        8'(ifc.busy), 8'd1);
    scan_mode = 0;
    wait_end(2000, d, e, r, cyc, row0);
    check("t6_done", 8'(d), 8'd1);
    check("t6_err",  8'(e), 8'd0);

    // Random traffic, including out-of-range keys and dropped commands
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rkey = $urandom_range(0, 13);
      send(rkey);
      if (rkey >= 12) begin
        @(negedge clk);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 20)) @(negedge clk);
          send($urandom_range(0, 13));
        end
        wait_end(2000, d, e, r, cyc, row0);
      end
    end

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
